// File: rtl/cmult_feeder.sv
// Issue stage for the complex multiplier: buffers I/Q samples and pairs each with a per-subcarrier
// coefficient, one multiplication in flight at a time. Optional feature macro: CMULT_FEEDER_CONJ_EN.
module cmult_feeder #(
  parameter int SIZE_DATA  = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int N_SUBCARR  = 64,
  parameter int ADDR_W     = 6,
  parameter int TIMEOUT    = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [SIZE_DATA-1:0] in_i,
  input  logic signed [SIZE_DATA-1:0] in_q,
  input  logic                        in_last,
  input  logic                        coef_we,
  input  logic [ADDR_W-1:0]           coef_waddr,
  input  logic signed [SIZE_DATA:0]   coef_wdata_i,
  input  logic signed [SIZE_DATA:0]   coef_wdata_q,
`ifdef CMULT_FEEDER_CONJ_EN
  input  logic                        coef_conj,
`endif
  output logic                        mult_en,
  output logic signed [SIZE_DATA-1:0] mult_d1_i,
  output logic signed [SIZE_DATA-1:0] mult_d1_q,
  output logic signed [SIZE_DATA:0]   mult_d2_i,
  output logic signed [SIZE_DATA:0]   mult_d2_q,
  input  logic                        mult_valid,
  output logic                        busy,
  output logic                        symbol_done,
  output logic                        timeout_err
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int CW    = SIZE_DATA + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT} state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_W-1:0]     subc_q, subc_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  last_q, last_d;
  logic                  timeout_err_q, timeout_err_d;
  logic signed [SIZE_DATA-1:0] d1_re_q, d1_re_d, d1_im_q, d1_im_d;
  logic signed [CW-1:0]        d2_re_q, d2_re_d, d2_im_q, d2_im_d;

  logic signed [SIZE_DATA-1:0] fifo_re   [FIFO_DEPTH];
  logic signed [SIZE_DATA-1:0] fifo_im   [FIFO_DEPTH];
  logic                        fifo_last [FIFO_DEPTH];
  logic signed [CW-1:0]        coef_re_ram [2**ADDR_W];
  logic signed [CW-1:0]        coef_im_ram [2**ADDR_W];
  logic signed [CW-1:0]        coef_rd_re_q, coef_rd_im_q;
  logic signed [CW-1:0]        coef_im_eff;

  logic push, pop, coef_rd_en, wait_exit;

  assign in_ready    = (count_q != CNT_W'(FIFO_DEPTH));
  assign busy        = (state_q != S_IDLE) || (count_q != '0);
  assign timeout_err = timeout_err_q;
  assign mult_d1_i   = d1_re_q;
  assign mult_d1_q   = d1_im_q;
  assign mult_d2_i   = d2_re_q;
  assign mult_d2_q   = d2_im_q;

`ifdef CMULT_FEEDER_CONJ_EN
  localparam logic signed [CW-1:0] COEF_MIN = {1'b1, {SIZE_DATA{1'b0}}};
  localparam logic signed [CW-1:0] COEF_MAX = {1'b0, {SIZE_DATA{1'b1}}};

  // Negating the most negative coefficient would overflow; clamp it to the positive maximum.
  always_comb begin
    coef_im_eff = coef_rd_im_q;
    if (coef_conj) begin
      coef_im_eff = (coef_rd_im_q == COEF_MIN) ? COEF_MAX : -coef_rd_im_q;
    end
  end
`else
  assign coef_im_eff = coef_rd_im_q;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_re[wr_ptr_q]   <= in_i;
      fifo_im[wr_ptr_q]   <= in_q;
      fifo_last[wr_ptr_q] <= in_last;
    end
  end

  // Registered read sees the pre-write contents on an address collision.
  always_ff @(posedge clk) begin
    if (coef_we) begin
      coef_re_ram[coef_waddr] <= coef_wdata_i;
      coef_im_ram[coef_waddr] <= coef_wdata_q;
    end
    if (coef_rd_en) begin
      coef_rd_re_q <= coef_re_ram[subc_q];
      coef_rd_im_q <= coef_im_ram[subc_q];
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    subc_d        = subc_q;
    timer_d       = timer_q;
    last_d        = last_q;
    timeout_err_d = timeout_err_q;
    d1_re_d       = d1_re_q;
    d1_im_d       = d1_im_q;
    d2_re_d       = d2_re_q;
    d2_im_d       = d2_im_q;
    push          = in_valid && in_ready;
    pop           = 1'b0;
    coef_rd_en    = 1'b0;
    mult_en       = 1'b0;
    symbol_done   = 1'b0;
    wait_exit     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          coef_rd_en = 1'b1;
          d1_re_d    = fifo_re[rd_ptr_q];
          d1_im_d    = fifo_im[rd_ptr_q];
          last_d     = fifo_last[rd_ptr_q];
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        d2_re_d = coef_rd_re_q;
        d2_im_d = coef_im_eff;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        mult_en = 1'b1;
        timer_d = TMR_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // timer_q counts WAIT cycles including the current one; a result on the last allowed cycle wins.
        if (mult_valid) begin
          wait_exit   = 1'b1;
          symbol_done = last_q;
        end else if (timer_q == TMR_W'(TIMEOUT)) begin
          wait_exit     = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wait_exit) begin
      state_d = S_IDLE;
      if (last_q || (subc_q == ADDR_W'(N_SUBCARR - 1))) begin
        subc_d = '0;
      end else begin
        subc_d = subc_q + 1'b1;
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      subc_q        <= '0;
      timer_q       <= '0;
      last_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      d1_re_q       <= '0;
      d1_im_q       <= '0;
      d2_re_q       <= '0;
      d2_im_q       <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      subc_q        <= subc_d;
      timer_q       <= timer_d;
      last_q        <= last_d;
      timeout_err_q <= timeout_err_d;
      d1_re_q       <= d1_re_d;
      d1_im_q       <= d1_im_d;
      d2_re_q       <= d2_re_d;
      d2_im_q       <= d2_im_d;
    end
  end

endmodule

// File: tb/tb_cmult_feeder.sv
// Bench for cmult_feeder: queue-based transaction model checked every cycle, plus directed
// scenarios with hand-computed timing and operand values.
module tb_cmult_feeder;
  localparam int SD = 16, CW = 17, DEPTH = 8, NSC = 4, AW = 6, TMO = 15;
  localparam int S_EN = 0, S_VALID = 1, S_TERR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic signed [SD-1:0] in_i = '0, in_q = '0;
  logic                 coef_we = 1'b0;
  logic [AW-1:0]        coef_waddr = '0;
  logic signed [CW-1:0] coef_wdata_i = '0, coef_wdata_q = '0;
  logic                 coef_conj = 1'b0;
  logic                 mult_en, busy, symbol_done, timeout_err, mult_valid;
  logic signed [SD-1:0] mult_d1_i, mult_d1_q;
  logic signed [CW-1:0] mult_d2_i, mult_d2_q;
  logic                 resp_v = 1'b0, extra_v = 1'b0;
  assign mult_valid = resp_v | extra_v;

  cmult_feeder #(.SIZE_DATA(SD), .FIFO_DEPTH(DEPTH), .N_SUBCARR(NSC), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q),
    .in_last(in_last), .coef_we(coef_we), .coef_waddr(coef_waddr), .coef_wdata_i(coef_wdata_i),
    .coef_wdata_q(coef_wdata_q),
`ifdef CMULT_FEEDER_CONJ_EN
    .coef_conj(coef_conj),
`endif
    .mult_en(mult_en), .mult_d1_i(mult_d1_i), .mult_d1_q(mult_d1_q), .mult_d2_i(mult_d2_i),
    .mult_d2_q(mult_d2_q), .mult_valid(mult_valid), .busy(busy), .symbol_done(symbol_done),
    .timeout_err(timeout_err)
  );

  typedef struct { int i; int q; bit last; } samp_t;
  samp_t acc_q[$];
  samp_t cur;
  int    cm_i[64], cm_q[64];
  int    idx = 0, wcyc = 0, exp_d2i = 0, exp_d2q = 0;
  bit    inflight = 0, terr_exp = 0, model_en = 0;
  int    cyc = 0, lat = 0, resp_cnt = 0, acc_cyc = 0, valid_cyc = 0;
  int    valid_count = 0, sd_count = 0, sd_at_valid = 0;
  int    issued_d2i[$];
  int    errs = 0, chks = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int conj_q(input int c, input bit conj);
    int v;
    if (!conj) return c;
    v = -c;
    if (v > (1 << SD) - 1) v = (1 << SD) - 1;
    return v;
  endfunction

  always @(posedge clk) cyc++;

  // Multiplier stand-in: raises outputValid `lat` cycles after the issue pulse (lat=0: never).
  always @(posedge clk) begin
    #1;
    resp_v = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) resp_v = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      acc_q.delete();
      inflight = 0;
      idx      = 0;
      terr_exp = 0;
    end else if (model_en) begin
      check("busy", busy, (acc_q.size() != 0) || inflight);
      check("timeout_err", timeout_err, terr_exp);
      if (inflight) begin
        wcyc++;
        check("mult_en_in_wait", mult_en, 0);
        check("hold_d1_i", mult_d1_i, cur.i);
        check("hold_d1_q", mult_d1_q, cur.q);
        check("hold_d2_i", mult_d2_i, exp_d2i);
        check("hold_d2_q", mult_d2_q, exp_d2q);
        if (mult_valid || wcyc == TMO) begin
          if (mult_valid) begin
            check("symbol_done", symbol_done, cur.last);
            valid_count++;
            valid_cyc = cyc;
            if (symbol_done) begin sd_count++; sd_at_valid = valid_count; end
          end else begin
            check("symbol_done_timeout", symbol_done, 0);
            terr_exp = 1;
          end
          idx      = cur.last ? 0 : (idx + 1) % NSC;
          inflight = 0;
        end else begin
          check("symbol_done_wait", symbol_done, 0);
        end
      end else begin
        check("symbol_done_idle", symbol_done, 0);
        if (mult_en) begin
          if (acc_q.size() == 0) begin
            check("mult_en_unexpected", mult_en, 0);
          end else begin
            cur     = acc_q.pop_front();
            exp_d2i = cm_i[idx];
            exp_d2q = conj_q(cm_q[idx], coef_conj);
            check("issue_d1_i", mult_d1_i, cur.i);
            check("issue_d1_q", mult_d1_q, cur.q);
            check("issue_d2_i", mult_d2_i, exp_d2i);
            check("issue_d2_q", mult_d2_q, exp_d2q);
            issued_d2i.push_back(exp_d2i);
            inflight = 1;
            wcyc     = 0;
            if (lat > 0) resp_cnt = lat;
          end
        end
      end
      if (in_valid && in_ready) acc_q.push_back('{i: int'(in_i), q: int'(in_q), last: in_last});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic write_coef(input int a, input int ci, input int cq);
    coef_we = 1'b1; coef_waddr = AW'(a); coef_wdata_i = CW'(ci); coef_wdata_q = CW'(cq);
    cm_i[a] = ci; cm_q[a] = cq;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic push_sample(input int si, input int sq, input bit sl);
    bit acc = 0;
    in_valid = 1'b1; in_i = SD'(si); in_q = SD'(sq); in_last = sl;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) acc_cyc = cyc;
      tick();
    end
    in_valid = 1'b0;
    check("push_accept", acc, 1);
  endtask

  task automatic wait_for(input int sel, input string name, output int at);
    bit hit = 0;
    at = -1;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(negedge clk);
      case (sel)
        S_EN:    hit = mult_en;
        S_VALID: hit = mult_valid;
        default: hit = timeout_err;
      endcase
      if (hit) at = cyc;
    end
    check(name, hit, 1);
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int n = 0; n < 400 && !idle; n++) begin
      @(negedge clk);
      idle = !busy && !inflight && (resp_cnt == 0) && (acc_q.size() == 0);
    end
    check("wait_idle", idle, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_en, t_v, t_e, first_acc;
    int exp4[5] = '{3, 10, -7, 1000, 3};

    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_mult_en", mult_en, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_d1_i", mult_d1_i, 0);
    check("rst_d2_q", mult_d2_q, 0);
    tick();
    rst = 1'b0;
    model_en = 1;

    write_coef(0, 3, -2);
    write_coef(1, 10, 20);
    write_coef(2, -7, 7);
    write_coef(3, 1000, -1000);
    write_coef(4, 55, 55);

    // Single sample: accepted at edge t, issue pulse captured at edge t+3, result 7 cycles later
    lat = 7;
    push_sample(100, -50, 0);
    wait_for(S_EN, "single_issue_seen", t_en);
    check("single_latency", t_en - acc_cyc, 3);
    check("single_d1_i", mult_d1_i, 100);
    check("single_d1_q", mult_d1_q, -50);
    check("single_d2_i", mult_d2_i, 3);
    check("single_d2_q", mult_d2_q, -2);
    wait_for(S_VALID, "single_valid_seen", t_v);
    check("single_valid_delay", t_v - t_en, 7);
    wait_idle();

    // Back-pressure: first sample waits 15 cycles (= TIMEOUT, still a valid exit) while 9 more arrive
    lat = 15;
    push_sample(1, 1, 0);
    wait_for(S_EN, "bp_issue_seen", t_en);
    tick();
    lat = 3;
    for (int k = 0; k < 8; k++) begin
      push_sample(10 + k, -k, 0);
      if (k == 0) first_acc = acc_cyc;
    end
    check("bp_back_to_back", acc_cyc - first_acc, 7);
    @(negedge clk);
    check("bp_in_ready_full", in_ready, 0);
    tick();
    push_sample(99, 99, 0);
    check("bp_release_after_pop", acc_cyc - valid_cyc, 2);
    wait_idle();
    check("bp_no_timeout", timeout_err, 0);

    // Symbol wrap: addresses 0,1,2,3 then last forces 0
    do_reset(2);
    lat = 2;
    sd_count = 0; valid_count = 0; sd_at_valid = 0;
    issued_d2i.delete();
    for (int k = 0; k < 5; k++) push_sample(200 + k, k, k == 3);
    wait_idle();
    check("wrap_issue_count", issued_d2i.size(), 5);
    for (int k = 0; k < 5; k++) check($sformatf("wrap_coef_%0d", k), issued_d2i[k], exp4[k]);
    check("wrap_symbol_done_count", sd_count, 1);
    check("wrap_symbol_done_on_4th", sd_at_valid, 4);

    // Timeout: no result ever returns; error flag rises the cycle after the 15th WAIT cycle
    do_reset(2);
    lat = 0;
    push_sample(5, 6, 0);
    wait_for(S_EN, "to_issue_seen", t_en);
    wait_for(S_TERR, "to_err_seen", t_e);
    check("to_err_delay", t_e - t_en, TMO + 1);
    tick();
    lat = 2;
    push_sample(7, 8, 0);
    wait_for(S_EN, "to_next_issue_seen", t_en);
    check("to_next_d2_i", mult_d2_i, 10);
    check("to_next_d2_q", mult_d2_q, 20);
    wait_idle();
    @(negedge clk);
    check("to_err_sticky", timeout_err, 1);
    tick();

    // Reset mid-operation: everything dropped, stale result ignored, nothing issued afterwards
    lat = 0;
    push_sample(1, 2, 0);
    push_sample(3, 4, 0);
    push_sample(5, 6, 0);
    repeat (4) tick();
    do_reset(1);
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_timeout_err", timeout_err, 0);
    tick();
    extra_v = 1'b1;
    tick();
    extra_v = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("mid_rst_no_issue", mult_en, 0);
    end
    tick();

`ifdef CMULT_FEEDER_CONJ_EN
    // Conjugate: most negative coefficient saturates, ordinary values negate
    do_reset(2);
    coef_conj = 1'b1;
    write_coef(0, 7, -65536);
    write_coef(1, 9, 5);
    lat = 1;
    push_sample(1, 1, 0);
    push_sample(2, 2, 0);
    wait_for(S_EN, "conj_issue0_seen", t_en);
    check("conj_sat_d2_q", mult_d2_q, 65535);
    tick();
    wait_for(S_EN, "conj_issue1_seen", t_en);
    check("conj_neg_d2_q", mult_d2_q, -5);
    wait_idle();
    coef_conj = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
